// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand/result bundle for the shift-and-add multiply sequencer.
// master = instruction decoder side, slave = sequencer side.
interface mul_seq_ctrl_if #(
  parameter int l = 16
);
  logic           start;
  logic [l-1:0]   X;
  logic [l-1:0]   Y;
  logic           busy;
  logic           done;
  logic [2*l-1:0] P;
  logic           Overflow;

  modport master (output start, X, Y, input busy, done, P, Overflow);
  modport slave  (input start, X, Y, output busy, done, P, Overflow);
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative multiplier: one l-bit add plus a right shift per cycle, l cycles per product.
// Define MUL_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module mul_seq_ctrl #(
  parameter int l = 16
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_ctrl_if.slave bus
);

  localparam int CW = (l > 1) ? $clog2(l) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [l-1:0]   m_reg;
  logic [l-1:0]   hi_reg;
  logic [l-1:0]   lo_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [2*l-1:0] p_reg;
  logic           ovf_reg;

  logic           last_step;
  logic [l-1:0]   addend;
  logic           cin;
  logic [l:0]     sum_ext;
  logic [l-1:0]   hi_next;
  logic [l-1:0]   lo_next;
  logic [2*l-1:0] prod_next;
  logic           ovf_next;

  assign last_step = (cnt_reg == CW'(l - 1));

  always_comb begin
    addend = '0;
    cin    = 1'b0;
`ifdef MUL_SIGNED_EN
    // Multiplier MSB carries negative weight, so the final step subtracts M.
    if (lo_reg[0]) begin
      addend = last_step ? ~m_reg : m_reg;
      cin    = last_step;
    end
    sum_ext = {hi_reg[l-1], hi_reg} + {addend[l-1], addend} + {{l{1'b0}}, cin};
`else
    if (lo_reg[0]) begin
      addend = m_reg;
    end
    sum_ext = {1'b0, hi_reg} + {1'b0, addend} + {{l{1'b0}}, cin};
`endif
    // Top bit of the l+1-bit sum (carry or sign) shifts into acc_hi's MSB.
    hi_next   = sum_ext[l:1];
    lo_next   = {sum_ext[0], lo_reg[l-1:1]};
    prod_next = {hi_next, lo_next};
`ifdef MUL_SIGNED_EN
    ovf_next  = (prod_next[2*l-1:l] != {l{prod_next[l-1]}});
`else
    ovf_next  = (prod_next[2*l-1:l] != '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      p_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == RUN) begin
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
        cnt_reg <= cnt_reg + 1'b1;
        if (last_step) begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          p_reg     <= prod_next;
          ovf_reg   <= ovf_next;
          cnt_reg   <= '0;
        end
      end else if (bus.start) begin
        // Accepted from IDLE or DONE; a start seen during RUN never reaches here.
        state_reg <= RUN;
        busy_reg  <= 1'b1;
        m_reg     <= bus.X;
        hi_reg    <= '0;
        lo_reg    <= bus.Y;
        cnt_reg   <= '0;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.P        = p_reg;
  assign bus.Overflow = ovf_reg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed literal cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_mul_seq_ctrl;

  localparam int L = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.l(L)) bus ();

  mul_seq_ctrl #(.l(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*L-1:0] ref_prod(input logic [L-1:0] a, input logic [L-1:0] b);
`ifdef MUL_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (2*L)'(sa * sb);
`else
    return (2*L)'(a) * (2*L)'(b);
`endif
  endfunction

  function automatic logic ref_ovf(input logic [2*L-1:0] p);
`ifdef MUL_SIGNED_EN
    return p[2*L-1:L] != {L{p[L-1]}};
`else
    return p[2*L-1:L] != '0;
`endif
  endfunction

  // Reference: each accepted start yields its product exactly L edges later.
  int             m_left = 0;
  logic           m_done = 1'b0;
  logic [2*L-1:0] m_p    = '0;
  logic [2*L-1:0] m_pend = '0;
  logic           m_ovf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_p    <= '0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_p    <= m_pend;
          m_ovf  <= ref_ovf(m_pend);
        end
      end else if (bus.start) begin
        m_pend <= ref_prod(bus.X, bus.Y);
        m_left <= L;
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_busy", 64'(bus.busy), 64'(m_left > 0));
      check("model_done", 64'(bus.done), 64'(m_done));
      check("model_P",    64'(bus.P),    64'(m_p));
      check("model_ovf",  64'(bus.Overflow), 64'(m_ovf));
    end
  end

  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
  task automatic do_start(input logic [L-1:0] x, input logic [L-1:0] y);
    bus.X     = x;
    bus.Y     = y;
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // n = cycles from acceptance until done is seen (bounded); b = cycles busy was high.
  task automatic wait_done(output int n, output int b);
    n = 1;
    b = bus.busy ? 1 : 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (bus.busy) b++;
    end while (!bus.done && n < 40);
  endtask

  task automatic run_op(input string name, input logic [L-1:0] x, input logic [L-1:0] y,
                        input logic [2*L-1:0] exp_p, input logic exp_ovf);
    int n;
    int b;
    do_start(x, y);
    wait_done(n, b);
    check({name, "_latency"}, 64'(n), 64'(17));
    check({name, "_busy_cycles"}, 64'(b), 64'(16));
    check({name, "_P"}, 64'(bus.P), 64'(exp_p));
    check({name, "_ovf"}, 64'(bus.Overflow), 64'(exp_ovf));
    $display("op %s: X=0x%04h Y=0x%04h P=0x%08h ovf=%0d latency=%0d", name, x, y, bus.P, bus.Overflow, n);
  endtask

  initial begin
    int n;
    int b;
    int dcnt;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;

    #12;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_P",    64'(bus.P),    64'(0));
    check("reset_ovf",  64'(bus.Overflow), 64'(0));
    @(negedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    run_op("3x5", 16'h0003, 16'h0005, 32'h0000000F, 1'b0);
`ifdef MUL_SIGNED_EN
    run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
    run_op("8000x2",    16'h8000, 16'h0002, 32'hFFFF0000, 1'b1);
    run_op("neg1x2",    16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b0);
    run_op("8000x8000", 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    run_op("3xneg5",    16'h0003, 16'hFFFB, 32'hFFFFFFF1, 1'b0);
`else
    run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run_op("8000x2",    16'h8000, 16'h0002, 32'h00010000, 1'b1);
`endif

    // Start during RUN is ignored; start during DONE is taken immediately.
    do_start(16'h0007, 16'h0009);
    repeat (3) @(negedge clk);
    #1;
    do_start(16'h0001, 16'h0001);
    wait_done(n, b);
    check("ignored_start_done", 64'(bus.done), 64'(1));
    check("ignored_start_P", 64'(bus.P), 64'(32'h0000003F));
    $display("op handshake_first: P=0x%08h", bus.P);
    run_op("start_in_done", 16'h0002, 16'h0100, 32'h00000200, 1'b0);

    // Asynchronous reset in the middle of an operation.
    do_start(16'h1234, 16'h0010);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_done", 64'(bus.done), 64'(0));
    check("async_rst_P",    64'(bus.P),    64'(0));
    check("async_rst_ovf",  64'(bus.Overflow), 64'(0));
    @(negedge clk);
    #1;
    rst  = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    #1;
    check("no_done_after_rst", 64'(dcnt), 64'(0));
    $display("op reset_midop: done pulses after reset=%0d", dcnt);
    run_op("after_rst", 16'h1234, 16'h0010, 32'h00012340, 1'b1);

    run_op("zero_x", 16'h0000, 16'hABCD, 32'h00000000, 1'b0);
`ifdef MUL_SIGNED_EN
    run_op("abcdx1", 16'hABCD, 16'h0001, 32'hFFFFABCD, 1'b0);
`else
    run_op("abcdx1", 16'hABCD, 16'h0001, 32'h0000ABCD, 1'b0);
`endif

    // Random traffic: starts arrive in any state; the model checks every cycle.
    for (int i = 0; i < 900; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       bus.X = 16'hFFFF;
        1:       bus.X = 16'h8000;
        2:       bus.X = 16'h0000;
        default: bus.X = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       bus.Y = 16'hFFFF;
        1:       bus.Y = 16'h8000;
        2:       bus.Y = 16'h0001;
        default: bus.Y = 16'($urandom);
      endcase
      if (i == 450) begin
        #3;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
      end else begin
        @(negedge clk);
        #1;
      end
      if (bus.done) $display("op random: cycle=%0d P=0x%08h ovf=%0d", i, bus.P, bus.Overflow);
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
